// File: rtl/ram_dp_be.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_be
// Brief    : Simple dual-port RAM with byte enables, 1/2-cycle read latency,
//            clear-on-reset sequencer and read-during-write collision flag.
//            Optional per-byte even parity when RAM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_be #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
`ifdef RAM_PARITY_EN
    input  logic                    par_inject,
    output logic                    rd_par_err,
`endif
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    collision
);

    localparam int                    c_NB    = DATA_WIDTH / 8;
    localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = '1;

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("ram_dp_be: DATA_WIDTH must be a multiple of 8");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("ram_dp_be: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  w_init_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_init_we   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we = 1'b1;
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    logic w_ready;
    logic w_usr_we;
    logic w_rd_acc;
    logic w_hit;

    assign w_ready   = (r_state == ST_READY);
    assign init_busy = ~w_ready;
    // A write with no byte enabled changes nothing, so it cannot collide.
    assign w_usr_we  = w_ready & wr_en & (|wr_be);
    assign w_rd_acc  = w_ready & rd_en;
    assign w_hit     = w_usr_we & (rd_addr == wr_addr);

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [c_NB-1:0]       w_be;

    always_comb begin
        w_we   = w_usr_we;
        w_addr = wr_addr;
        w_data = wr_data;
        w_be   = wr_be;
        if (w_init_we) begin
            w_we   = 1'b1;
            w_addr = r_cnt;
            w_data = INIT_VALUE;
            w_be   = '1;
        end
    end

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < c_NB; i++) begin
                if (w_be[i]) begin
                    r_mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [c_NB-1:0] r_par [c_DEPTH];
    logic [c_NB-1:0] w_wpar;
    logic            w_rd_perr;

    // Injection only applies to user writes; the clear pass always stores good parity.
    always_comb begin
        w_wpar = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_wpar[i] = (^w_data[8*i +: 8]) ^ (par_inject & ~w_init_we);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < c_NB; i++) begin
                if (w_be[i]) begin
                    r_par[w_addr][i] <= w_wpar[i];
                end
            end
        end
    end

    always_comb begin
        w_rd_perr = 1'b0;
        for (int i = 0; i < c_NB; i++) begin
            w_rd_perr = w_rd_perr | ((^r_mem[rd_addr][8*i +: 8]) ^ r_par[rd_addr][i]);
        end
    end
`endif

    // Read-first: the registered word is the pre-write content on a same-address hit.
    logic                  r_v1;
    logic                  r_c1;
    logic [DATA_WIDTH-1:0] r_d1;
`ifdef RAM_PARITY_EN
    logic                  r_pe1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_c1  <= 1'b0;
            r_d1  <= '0;
`ifdef RAM_PARITY_EN
            r_pe1 <= 1'b0;
`endif
        end else begin
            r_v1  <= w_rd_acc;
            r_c1  <= w_rd_acc & w_hit;
`ifdef RAM_PARITY_EN
            r_pe1 <= w_rd_acc & w_rd_perr;
`endif
            if (w_rd_acc) begin
                r_d1 <= r_mem[rd_addr];
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  r_v2;
            logic                  r_c2;
            logic [DATA_WIDTH-1:0] r_d2;
`ifdef RAM_PARITY_EN
            logic                  r_pe2;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2  <= 1'b0;
                    r_c2  <= 1'b0;
                    r_d2  <= '0;
`ifdef RAM_PARITY_EN
                    r_pe2 <= 1'b0;
`endif
                end else begin
                    r_v2  <= r_v1;
                    r_c2  <= r_c1;
`ifdef RAM_PARITY_EN
                    r_pe2 <= r_pe1;
`endif
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign rd_valid   = r_v2;
            assign collision  = r_c2;
            assign rd_data    = r_d2;
`ifdef RAM_PARITY_EN
            assign rd_par_err = r_pe2;
`endif
        end else begin : g_lat1
            assign rd_valid   = r_v1;
            assign collision  = r_c1;
            assign rd_data    = r_d1;
`ifdef RAM_PARITY_EN
            assign rd_par_err = r_pe1;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, per-byte write enables.
- Configurable read latency, hardware clear-on-reset sequencer, read-during-write collision flag.
- Next-generation DUT for the RAM verification environment, replacing the fixed-width single-port RAM.
- Sits behind the bench's write and read drivers, which drive the two ports independently.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH (64).
- RD_LATENCY, 1, read latency in cycles from rd_en to rd_valid; legal values 1 or 2.
- INIT_VALUE, 0, value written to every word by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_busy  out  1  high while the clear sequencer runs.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- collision  out  1  qualifies rd_valid; read address matched an effective write in the request cycle.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - init_busy=1, rd_data=0, rd_valid=0, collision=0.
  - FSM=INIT, clear counter=0, read pipeline flushed.
- FSM state INIT:
  - Writes INIT_VALUE to address = counter each cycle; counter increments.
  - After address DEPTH-1 is written, FSM moves to READY.
  - init_busy falls on the first READY cycle, i.e. DEPTH cycles after rst_n rises.
  - wr_en and rd_en are ignored: no memory update, no rd_valid.
- FSM state READY:
  - Write: when wr_en=1, bytes with wr_be[i]=1 are updated at the clock edge. Other bytes are unchanged.
  - wr_en=1 with wr_be=0 is a no-op.
  - Read: rd_en sampled at edge N gives rd_valid=1 and rd_data at edge N+RD_LATENCY.
  - Back-to-back reads give back-to-back valids, in order; throughput is 1 read per cycle.
  - rd_data holds its last value while rd_valid=0.
- Read-during-write, same cycle, rd_addr==wr_addr, wr_en=1 and wr_be!=0:
  - Read-first: returns pre-write data.
  - collision=1, aligned with that rd_valid.
  - Different addresses never raise collision.
- No collision-related stall; both ports are always ready in READY.
- Reset mid-operation:
  - In-flight reads are dropped.
  - Sequencer restarts from address 0.
  - All contents are re-cleared to INIT_VALUE.
- Elaboration-time error if DATA_WIDTH%8 != 0 or RD_LATENCY is not in {1,2}.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, written with the data and updated per byte enable.
  - Extra input par_inject (1): when high during a write, the parity of enabled bytes is inverted.
  - Extra output rd_par_err (1): asserted with rd_valid if any read byte's parity mismatches.
  - The clear sequencer writes correct parity; rd_par_err resets to 0.
- Undefined: no parity storage, no par_inject/rd_par_err ports; all other behaviour is identical.

Test Plan:
- Release reset, defaults: init_busy high exactly 64 cycles; then rd_en at addr 5 gives rd_valid 1 cycle later, rd_data=0, collision=0.
- Full write: addr 0x0A, 0xDEADBEEF, be=4'hF; read 0x0A gives 0xDEADBEEF.
- Byte enables: write 0x11223344 be=4'b0101 to 0x0A; read gives 0xDE22BE44.
- Collision: same cycle write 0xCAFEF00D (be=4'hF) and read 0x0A; rd_data=0xDE22BE44 with collision=1. Next read gives 0xCAFEF00D with collision=0.
- RD_LATENCY=2: reads of addrs 1,2,3 on consecutive cycles give rd_valid on cycles +2,+3,+4 with data in order. A write during INIT followed by a read after INIT returns 0.
- rst_n low for 1 cycle with a read in flight: rd_valid=0 immediately, init_busy=1 for 64 cycles; addr 0x0A then reads 0. With RAM_PARITY_EN, a write with par_inject=1 then read gives rd_par_err=1.
